fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the next-generation RV32I core. Replaces the combinational PC-indexed ROM fetch with a decoupled unit: it issues sequential word fetches over a valid/ready request channel to a variable-latency instruction memory, tracks up to DEPTH outstanding or buffered fetches, and delivers {pc, instr} pairs in order to decode over a valid/ready channel. Branch/jump redirects flush all buffered and in-flight fetches and restart at the new PC.

---
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled in-order instruction fetch queue with redirect flush
// Ports: clk, rst (async active-low); redirect_valid/redirect_pc restart fetch at a new PC;
// imem_req_valid/ready/addr issue word fetches; imem_rsp_valid/data return them in order (no backpressure);
// out_valid/ready/pc/instr deliver fetched words to decode; occupancy counts allocated entries.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pc [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]   r_alloc_ptr, r_fill_ptr, r_head_ptr;
  logic [CW-1:0]   r_alloc_cnt, r_drop_cnt;
  // allocated entries still awaiting data; pointers alone cannot tell all-pending from none-pending
  logic [CW-1:0]   r_pend_cnt;
  logic w_room, w_req, w_pop, w_fill, w_drop;
  // credit: every allocated or still-to-be-dropped fetch holds one slot
  assign w_room = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt} < DEPTH_C;
  assign imem_req_valid = rst && !redirect_valid && w_room;
  assign imem_req_addr = r_fetch_pc;
  assign w_req = imem_req_valid && imem_req_ready;
  assign out_valid = r_filled[r_head_ptr] && r_alloc_cnt != '0;
  assign out_pc = r_pc[r_head_ptr];
  assign out_instr = r_instr[r_head_ptr];
  assign occupancy = r_alloc_cnt;
  assign w_pop = out_valid && out_ready;
  assign w_drop = imem_rsp_valid && r_drop_cnt != '0;
  // unsolicited responses (nothing pending, nothing to drop) are ignored
  assign w_fill = imem_rsp_valid && r_drop_cnt == '0 && r_pend_cnt != '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_alloc_ptr <= '0;
      r_fill_ptr <= '0;
      r_head_ptr <= '0;
      r_alloc_cnt <= '0;
      r_drop_cnt <= '0;
      r_pend_cnt <= '0;
      r_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i] <= '0;
        r_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~XLEN'(3);
      r_alloc_ptr <= '0;
      r_fill_ptr <= '0;
      r_head_ptr <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt <= '0;
      r_filled <= '0;
      // still-owed responses become drops; one arriving now is consumed here
      r_drop_cnt <= r_drop_cnt + r_pend_cnt - CW'(w_drop || w_fill);
    end else begin
      if (w_req) begin
        r_pc[r_alloc_ptr] <= r_fetch_pc;
        r_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr <= r_alloc_ptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_fill) begin
        r_instr[r_fill_ptr] <= imem_rsp_data;
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr <= r_fill_ptr + 1'b1;
      end
      if (w_pop) r_head_ptr <= r_head_ptr + 1'b1;
      r_drop_cnt <= r_drop_cnt - CW'(w_drop);
      r_alloc_cnt <= r_alloc_cnt + CW'(w_req) - CW'(w_pop);
      r_pend_cnt <= r_pend_cnt + CW'(w_req) - CW'(w_fill);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a variable-latency memory
module tb_fetch_queue;
  logic clk = 0;
  logic rst = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic out_valid;
  logic out_ready = 1;
  logic [31:0] out_pc, out_instr;
  logic [2:0] occupancy;
  int checks = 0;
  int errors = 0;
  int lat = 1;
  bit toggle = 0;
  int cyc = 0;
  typedef struct {logic [31:0] a; int due;} ent_t;
  ent_t mq[$];
  logic [31:0] acc_q[$];
  int acc_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // memory model plus accept/pop loggers; samples pre-edge values, drives just after the edge
  initial begin
    imem_req_ready = 1;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) mq.delete();
      else begin
        if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          mq.push_back('{a: imem_req_addr, due: cyc + lat - 1});
          acc_q.push_back(imem_req_addr);
          acc_cyc.push_back(cyc);
        end
        if (out_valid && out_ready && !redirect_valid) begin
          pop_pc.push_back(out_pc);
          pop_ins.push_back(out_instr);
        end
      end
      #1;
      imem_rsp_valid = rst && mq.size() > 0 && mq[0].due <= cyc;
      imem_rsp_data = imem_rsp_valid ? mem_word(mq[0].a) : 32'h0;
      imem_req_ready = toggle ? cyc[0] : 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc.delete();
    pop_pc.delete();
    pop_ins.delete();
  endtask

  task automatic do_reset();
    rst = 0;
    redirect_valid = 0;
    tick();
    tick();
    clear_logs();
    rst = 1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL rst_req_addr got %h exp 00000100", imem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc got %h exp 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got %h exp 0", out_instr); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", occupancy); end
    clear_logs();
    rst = 1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL release_req_addr got %h exp 00000100", imem_req_addr); end
  endtask

  task automatic test_stream();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %b exp 0", out_valid); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stream_first_occ got %0d exp 1", occupancy); end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL stream_out_pc[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_pc, 32'h100 + 32'(4 * i)); end
      checks++; if (out_instr !== mem_word(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL stream_out_instr[%0d] got %h exp %h", i, out_instr, mem_word(32'h100 + 32'(4 * i))); end
      if (i < 5) tick();
    end
    checks++; if (acc_q.size() != 7) begin errors++; $display("FAIL stream_accepts got %0d exp 7", acc_q.size()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== 32'h100 + 32'(4 * i) || acc_cyc[i] != acc_cyc[0] + i) begin errors++; $display("FAIL stream_req[%0d] got %h@%0d exp %h@%0d", i, acc_q[i], acc_cyc[i], 32'h100 + 32'(4 * i), acc_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    lat = 1;
    out_ready = 0;
    do_reset();
    repeat (8) tick();
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL bp_accepts got %0d exp 4", acc_q.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy got %0d exp 4", occupancy); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL bp_head got v=%b %h exp v=1 00000100", out_valid, out_pc); end
    out_ready = 1;
    repeat (8) tick();
    checks++; if (pop_pc.size() < 4 || acc_q.size() < 5) begin errors++; $display("FAIL bp_drain_counts got pops=%0d acc=%0d exp >=4 >=5", pop_pc.size(), acc_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (pop_pc[i] !== 32'h100 + 32'(4 * i) || pop_ins[i] !== mem_word(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL bp_pop[%0d] got %h/%h exp %h", i, pop_pc[i], pop_ins[i], 32'h100 + 32'(4 * i)); end
      end
      checks++; if (acc_q[4] !== 32'h110) begin errors++; $display("FAIL bp_resume_addr got %h exp 00000110", acc_q[4]); end
    end
  endtask

  task automatic test_latency_toggle();
    logic stall;
    logic [31:0] paddr;
    lat = 3;
    toggle = 1;
    out_ready = 1;
    do_reset();
    stall = 0;
    paddr = 0;
    for (int i = 0; i < 40; i++) begin
      if (stall) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== paddr) begin errors++; $display("FAIL lat_hold got v=%b %h exp v=1 %h", imem_req_valid, imem_req_addr, paddr); end
      end
      stall = imem_req_valid && !imem_req_ready;
      paddr = imem_req_addr;
      tick();
    end
    toggle = 0;
    checks++; if (pop_pc.size() < 8) begin errors++; $display("FAIL lat_pop_count got %0d exp >=8", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== 32'h100 + 32'(4 * i) || pop_ins[i] !== mem_word(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL lat_pop[%0d] got %h/%h exp %h", i, pop_pc[i], pop_ins[i], 32'h100 + 32'(4 * i)); end
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL lat_req[%0d] got %h exp %h", i, acc_q[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    lat = 4;
    out_ready = 1;
    do_reset();
    repeat (3) tick();
    checks++; if (acc_q.size() != 3 || occupancy !== 3'd3 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_pre got acc=%0d occ=%0d v=%b exp 3 3 0", acc_q.size(), occupancy, out_valid); end
    redirect_pc = 32'h203;
    redirect_valid = 1;
    tick();
    redirect_valid = 0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL redir_req got v=%b %h exp v=1 00000200", imem_req_valid, imem_req_addr); end
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got occ=%0d v=%b exp 0 0", occupancy, out_valid); end
    repeat (12) tick();
    checks++; if (pop_pc.size() < 2 || acc_q.size() < 4) begin errors++; $display("FAIL redir_counts got pops=%0d acc=%0d exp >=2 >=4", pop_pc.size(), acc_q.size()); end
    else begin
      checks++; if (acc_q[3] !== 32'h200) begin errors++; $display("FAIL redir_acc got %h exp 00000200", acc_q[3]); end
      checks++; if (pop_pc[0] !== 32'h200 || pop_ins[0] !== mem_word(32'h200)) begin errors++; $display("FAIL redir_pop0 got %h/%h exp 00000200/%h", pop_pc[0], pop_ins[0], mem_word(32'h200)); end
      checks++; if (pop_pc[1] !== 32'h204 || pop_ins[1] !== mem_word(32'h204)) begin errors++; $display("FAIL redir_pop1 got %h/%h exp 00000204/%h", pop_pc[1], pop_ins[1], mem_word(32'h204)); end
    end
  endtask

  task automatic test_redirect_collide();
    lat = 2;
    out_ready = 1;
    do_reset();
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1 || imem_rsp_valid !== 1'b1 || out_pc !== 32'h104 || occupancy !== 3'd3) begin errors++; $display("FAIL col_pre got v=%b rsp=%b pc=%h occ=%0d exp 1 1 00000104 3", out_valid, imem_rsp_valid, out_pc, occupancy); end
    redirect_pc = 32'h300;
    redirect_valid = 1;
    tick();
    redirect_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL col_flush got v=%b occ=%0d exp 0 0", out_valid, occupancy); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin errors++; $display("FAIL col_req got v=%b %h exp v=1 00000300", imem_req_valid, imem_req_addr); end
    repeat (10) tick();
    checks++; if (pop_pc.size() < 3) begin errors++; $display("FAIL col_pop_count got %0d exp >=3", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[0] !== 32'h100) begin errors++; $display("FAIL col_pop0 got %h exp 00000100", pop_pc[0]); end
      checks++; if (pop_pc[1] !== 32'h300 || pop_ins[1] !== mem_word(32'h300)) begin errors++; $display("FAIL col_pop1 got %h/%h exp 00000300/%h", pop_pc[1], pop_ins[1], mem_word(32'h300)); end
      checks++; if (pop_pc[2] !== 32'h304 || pop_ins[2] !== mem_word(32'h304)) begin errors++; $display("FAIL col_pop2 got %h/%h exp 00000304/%h", pop_pc[2], pop_ins[2], mem_word(32'h304)); end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    lat = 1;
    out_ready = 1;
    do_reset();
    redirect_pc = 32'hFFFF_FFF8;
    redirect_valid = 1;
    tick();
    redirect_valid = 0;
    repeat (6) tick();
    checks++; if (acc_q.size() < 3 || pop_pc.size() < 3) begin errors++; $display("FAIL wrap_counts got acc=%0d pops=%0d exp >=3 >=3", acc_q.size(), pop_pc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (acc_q[i] !== exp_pc[i]) begin errors++; $display("FAIL wrap_req[%0d] got %h exp %h", i, acc_q[i], exp_pc[i]); end
        checks++; if (pop_pc[i] !== exp_pc[i] || pop_ins[i] !== mem_word(exp_pc[i])) begin errors++; $display("FAIL wrap_pop[%0d] got %h/%h exp %h/%h", i, pop_pc[i], pop_ins[i], exp_pc[i], mem_word(exp_pc[i])); end
      end
    end
    #2;
    rst = 0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL arst_req got v=%b %h exp v=0 00000100", imem_req_valid, imem_req_addr); end
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL arst_out got v=%b %h %h exp 0 0 0", out_valid, out_pc, out_instr); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL arst_occ got %0d exp 0", occupancy); end
    tick();
    tick();
    clear_logs();
    rst = 1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL arst_restart got v=%b %h exp v=1 00000100", imem_req_valid, imem_req_addr); end
    repeat (4) tick();
    checks++; if (pop_pc.size() < 1) begin errors++; $display("FAIL arst_pop_count got %0d exp >=1", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[0] !== 32'h100 || pop_ins[0] !== mem_word(32'h100)) begin errors++; $display("FAIL arst_pop0 got %h/%h exp 00000100/%h", pop_pc[0], pop_ins[0], mem_word(32'h100)); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency_toggle();
    test_redirect();
    test_redirect_collide();
    test_wrap_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
